alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences one conditional ALU operation at a time: accept, evaluate the ARM
// condition, drive the external ALU for one cycle, then hold the response.
module alu_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_uop,
  input  logic [31:0]      req_lhs,
  input  logic [31:0]      req_rhs,
  input  logic [3:0]       req_cond,
  input  logic             req_setflags,
  input  logic [TAG_W-1:0] req_rd,
  output logic [4:0]       alu_uop,
  output logic [31:0]      alu_lhs,
  output logic [31:0]      alu_rhs,
  input  logic [31:0]      alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             rsp_we,
  output logic [3:0]       flags_q,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [4:0] UOP_CMP = 5'd5;

  logic [1:0]       r_state;
  logic [4:0]       r_uop;
  logic [31:0]      r_lhs;
  logic [31:0]      r_rhs;
  logic [TAG_W-1:0] r_rd;
  logic             r_setflags;
  logic [3:0]       r_flags;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_we;

  logic w_cond_pass;
  logic w_uop_valid;
  logic w_flag_load;
  logic w_exec;

  // Flags are packed [Z,C,N,V] with Z in bit 3.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c && !z;
      4'd9:    cond_eval = !c || z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z && (n == v);
      4'd13:   cond_eval = z || (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign w_cond_pass = cond_eval(req_cond, r_flags);
  assign w_uop_valid = (r_uop >= 5'd1) && (r_uop <= 5'd8);
  assign w_flag_load = w_uop_valid && (r_setflags || (r_uop == UOP_CMP));
  assign w_exec      = (r_state == ST_EXEC);

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values of each other; a blocking = would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_uop      <= '0;
      r_lhs      <= '0;
      r_rhs      <= '0;
      r_rd       <= '0;
      r_setflags <= 1'b0;
      r_flags    <= '0;
      r_rsp_data <= '0;
      r_rsp_we   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_uop      <= req_uop;
            r_lhs      <= req_lhs;
            r_rhs      <= req_rhs;
            r_rd       <= req_rd;
            r_setflags <= req_setflags;
            if (w_cond_pass) begin
              r_state <= ST_EXEC;
            end else begin
              // Skipped operation: answer at once with an empty, non-writing response.
              r_state    <= ST_RESP;
              r_rsp_data <= '0;
              r_rsp_we   <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_data <= alu_out;
          r_rsp_we   <= w_uop_valid && (r_uop != UOP_CMP);
          if (w_flag_load) r_flags <= alu_flags;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // rst_n gates req_ready directly so nothing is offered while reset is held.
  assign req_ready = (r_state == ST_IDLE) && rst_n;
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rd;
  assign rsp_we    = r_rsp_we;
  assign flags_q   = r_flags;

  assign alu_uop = w_exec ? r_uop : 5'd0;
  assign alu_lhs = w_exec ? r_lhs : 32'd0;
  assign alu_rhs = w_exec ? r_rhs : 32'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a table of conditional operations run
// back to back through a behavioural ALU, plus back-pressure and reset sequences.
module tb_alu_sequencer;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_uop;
  logic [31:0]      req_lhs;
  logic [31:0]      req_rhs;
  logic [3:0]       req_cond;
  logic             req_setflags;
  logic [TAG_W-1:0] req_rd;
  logic [4:0]       alu_uop;
  logic [31:0]      alu_lhs;
  logic [31:0]      alu_rhs;
  logic [31:0]      alu_out;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;
  logic             rsp_we;
  logic [3:0]       flags_q;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_uop      (req_uop),
    .req_lhs      (req_lhs),
    .req_rhs      (req_rhs),
    .req_cond     (req_cond),
    .req_setflags (req_setflags),
    .req_rd       (req_rd),
    .alu_uop      (alu_uop),
    .alu_lhs      (alu_lhs),
    .alu_rhs      (alu_rhs),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_rd       (rsp_rd),
    .rsp_we       (rsp_we),
    .flags_q      (flags_q),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 CMP, 6 MOV, 7 EOR, 8 BIC.
  // Unknown codes return a marker value with all flags set.
  logic [32:0] alu_sum;
  logic        alu_c;
  logic        alu_v;
  always_comb begin
    alu_out   = 32'd0;
    alu_flags = 4'd0;
    alu_sum   = 33'd0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (alu_uop)
      5'd1: begin
        alu_sum = {1'b0, alu_lhs} + {1'b0, alu_rhs};
        alu_out = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (alu_lhs[31] == alu_rhs[31]) && (alu_out[31] != alu_lhs[31]);
      end
      5'd2, 5'd5: begin
        alu_out = alu_lhs - alu_rhs;
        alu_c   = (alu_lhs >= alu_rhs);
        alu_v   = (alu_lhs[31] != alu_rhs[31]) && (alu_out[31] != alu_lhs[31]);
      end
      5'd3: alu_out = alu_lhs & alu_rhs;
      5'd4: alu_out = alu_lhs | alu_rhs;
      5'd6: alu_out = alu_rhs;
      5'd7: alu_out = alu_lhs ^ alu_rhs;
      5'd8: alu_out = alu_lhs & ~alu_rhs;
      default: alu_out = 32'hDEADBEEF;
    endcase
    if (alu_uop >= 5'd1 && alu_uop <= 5'd8)
      alu_flags = {(alu_out == 32'd0), alu_c, alu_out[31], alu_v};
    else
      alu_flags = 4'b1111;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]       uop;
    logic [31:0]      lhs;
    logic [31:0]      rhs;
    logic [3:0]       cond;
    logic             sf;
    logic [TAG_W-1:0] rd;
    logic             pass;
    logic [31:0]      data;
    logic             we;
    logic [3:0]       flags;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  // Offers one operation at a negedge, measures latency, checks the response
  // and completes the handshake.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_uop      = v.uop;
    req_lhs      = v.lhs;
    req_rhs      = v.rhs;
    req_cond     = v.cond;
    req_setflags = v.sf;
    req_rd       = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.pass) begin
      check({tag, " exec alu_uop"}, 32'(alu_uop), 32'(v.uop));
      check({tag, " exec alu_lhs"}, alu_lhs, v.lhs);
    end else begin
      check({tag, " skip alu_uop"}, 32'(alu_uop), 32'd0);
    end
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), v.pass ? 32'd2 : 32'd1);
    check({tag, " rsp_data"}, rsp_data, v.data);
    check({tag, " rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
    check({tag, " rsp_we"}, 32'(rsp_we), 32'(v.we));
    check({tag, " flags_q"}, 32'(flags_q), 32'(v.flags));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    //              uop    lhs           rhs           cond   sf    rd     pass  data          we    flags
    vecs[0]  = '{5'd1,  32'h0,        32'h1,        4'd0 + 4'd14, 1'b0, 4'd3,  1'b1, 32'h1,        1'b1, 4'b0000};
    vecs[1]  = '{5'd2,  32'h1,        32'h1,        4'd14, 1'b1, 4'd4,  1'b1, 32'h0,        1'b1, 4'b1100};
    vecs[2]  = '{5'd1,  32'h7FFFFFFF, 32'h1,        4'd10, 1'b1, 4'd5,  1'b1, 32'h80000000, 1'b1, 4'b0011};
    vecs[3]  = '{5'd5,  32'h5,        32'h5,        4'd10, 1'b0, 4'd6,  1'b1, 32'h0,        1'b0, 4'b1100};
    vecs[4]  = '{5'd6,  32'h0,        32'h12345678, 4'd0,  1'b0, 4'd6,  1'b1, 32'h12345678, 1'b1, 4'b1100};
    vecs[5]  = '{5'd6,  32'h0,        32'hAAAA,     4'd1,  1'b0, 4'd7,  1'b0, 32'h0,        1'b0, 4'b1100};
    vecs[6]  = '{5'd1,  32'h2,        32'h2,        4'd8,  1'b0, 4'd8,  1'b0, 32'h0,        1'b0, 4'b1100};
    vecs[7]  = '{5'd1,  32'h2,        32'h2,        4'd9,  1'b1, 4'd1,  1'b1, 32'h4,        1'b1, 4'b0000};
    vecs[8]  = '{5'd2,  32'h3,        32'h5,        4'd3,  1'b1, 4'd2,  1'b1, 32'hFFFFFFFE, 1'b1, 4'b0010};
    vecs[9]  = '{5'd7,  32'hFF,       32'h0F,       4'd11, 1'b0, 4'd9,  1'b1, 32'hF0,       1'b1, 4'b0010};
    vecs[10] = '{5'd1,  32'h1,        32'h1,        4'd15, 1'b0, 4'd10, 1'b0, 32'h0,        1'b0, 4'b0010};
    vecs[11] = '{5'd5,  32'h1,        32'h2,        4'd4,  1'b0, 4'd11, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b0010};
    vecs[12] = '{5'd3,  32'hF0,       32'h0F,       4'd14, 1'b1, 4'd12, 1'b1, 32'h0,        1'b1, 4'b1000};
    vecs[13] = '{5'h1F, 32'h3,        32'h4,        4'd14, 1'b1, 4'd13, 1'b1, 32'hDEADBEEF, 1'b0, 4'b1000};
    vecs[14] = '{5'd0,  32'h3,        32'h4,        4'd0,  1'b1, 4'd14, 1'b1, 32'hDEADBEEF, 1'b0, 4'b1000};
    vecs[15] = '{5'd4,  32'h1,        32'h2,        4'd12, 1'b0, 4'd15, 1'b0, 32'h0,        1'b0, 4'b1000};
    vecs[16] = '{5'd4,  32'h1,        32'h2,        4'd7,  1'b1, 4'd0,  1'b1, 32'h3,        1'b1, 4'b0000};
    vecs[17] = '{5'd8,  32'hFF,       32'h0F,       4'd5,  1'b0, 4'd1,  1'b1, 32'hF0,       1'b1, 4'b0000};
    vecs[18] = '{5'd2,  32'h4,        32'h4,        4'd13, 1'b1, 4'd2,  1'b0, 32'h0,        1'b0, 4'b0000};
    vecs[19] = '{5'd1,  32'hFFFFFFFF, 32'h1,        4'd14, 1'b1, 4'd3,  1'b1, 32'h0,        1'b1, 4'b1100};
    vecs[20] = '{5'd1,  32'h0,        32'h5,        4'd2,  1'b0, 4'd4,  1'b1, 32'h5,        1'b1, 4'b1100};
    vecs[21] = '{5'd9,  32'h1,        32'h1,        4'd6,  1'b1, 4'd5,  1'b0, 32'h0,        1'b0, 4'b1100};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_uop      = '0;
    req_lhs      = '0;
    req_rhs      = '0;
    req_cond     = '0;
    req_setflags = 1'b0;
    req_rd       = '0;
    rsp_ready    = 1'b0;

    #12;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset flags_q", 32'(flags_q), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset alu_uop", 32'(alu_uop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: response must hold steady while rsp_ready stays low.
    @(negedge clk);
    req_valid = 1'b1; req_uop = 5'd1; req_lhs = 32'd10; req_rhs = 32'd20;
    req_cond = 4'd14; req_setflags = 1'b0; req_rd = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_data", i), rsp_data, 32'd30);
      check($sformatf("bp%0d rsp_rd", i), 32'(rsp_rd), 32'd9);
      check($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d busy", i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp release req_ready", 32'(req_ready), 32'd1);
    check("bp release busy", 32'(busy), 32'd0);
    check("bp flags_q", 32'(flags_q), 32'(4'b1100));

    // Reset asserted while ADD 7+1 sits in EXEC.
    req_valid = 1'b1; req_uop = 5'd1; req_lhs = 32'd7; req_rhs = 32'd1;
    req_cond = 4'd14; req_setflags = 1'b1; req_rd = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst exec alu_uop", 32'(alu_uop), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst async busy", 32'(busy), 32'd0);
    check("rst async alu_uop", 32'(alu_uop), 32'd0);
    check("rst async alu_lhs", alu_lhs, 32'd0);
    check("rst async flags_q", 32'(flags_q), 32'd0);
    check("rst async rsp_rd", 32'(rsp_rd), 32'd0);
    check("rst async req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst after%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      check($sformatf("rst after%0d req_ready", i), 32'(req_ready), 32'd1);
    end
    check("rst after flags_q", 32'(flags_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
